sdpram_be_model: RTL
====================

// Module: sdpram_be_model
// PURPOSE
//  Parametrised single-clock simple-dual-port RAM model with byte-enable writes,
//  selectable read latency, defined read-during-write behaviour and a hardware
//  clear sequencer. Successor to the two-clock RAM model, used as the
//  quotient/remainder scratch store beside the divider datapath.
// PARAMETERS
//  P_LENGTH      1024   number of words
//  P_ADDR_LEN    10     address width; 2**P_ADDR_LEN >= P_LENGTH
//  P_BITDEPTH    32     word width; must be a multiple of 8
//  P_BE_WIDTH    4      byte lanes = P_BITDEPTH/8
//  P_RD_LATENCY  1      read latency in cycles; legal values 1 or 2
//  P_RDW_MODE    0      same-address read+write: 0=old data, 1=new (merged) data
//  P_CLR_VALUE   0      word value written by the clear sequencer
// PORTS
//  i_clk      in   1            clock, all logic on rising edge
//  i_rstn     in   1            asynchronous active-low reset
//  i_clr      in   1            pulse: start clear sequence (ignored while o_busy)
//  o_busy     out  1            1 while clear sequence runs; accesses ignored
//  i_rden     in   1            read request
//  i_rdaddr   in   P_ADDR_LEN   read address
//  o_rddata   out  P_BITDEPTH   read data
//  o_rdvalid  out  1            1-cycle pulse: o_rddata carries a new result
//  i_wren     in   1            write request
//  i_wrbe     in   P_BE_WIDTH   byte enables, bit k -> bits [8k+7:8k]
//  i_wraddr   in   P_ADDR_LEN   write address
//  i_wrdata   in   P_BITDEPTH   write data
//  o_err      out  1            sticky: out-of-range access seen
// BEHAVIOUR
//  Reset (i_rstn=0): o_rddata=0, o_rdvalid=0, o_err=0, o_busy=1, FSM=CLEAR,
//   clear counter=0, read pipeline valids=0. Array itself has no reset.
//  FSM: CLEAR -> IDLE when counter==P_LENGTH-1 (last word written that cycle);
//   IDLE -> CLEAR on i_clr=1 (counter reloads 0, o_err cleared).
//   CLEAR writes P_CLR_VALUE to word[counter], counter++ per cycle; lasts exactly
//   P_LENGTH cycles; o_busy=1 in CLEAR, 0 in IDLE.
//  Reset mid-CLEAR: sequence restarts from address 0 after release.
//  i_clr during CLEAR: ignored. i_clr with i_rden/i_wren in IDLE: clear wins,
//   access that cycle dropped.
//  While o_busy: i_rden/i_wren ignored, no o_rdvalid generated, o_err unaffected.
//  Read: i_rden=1 in IDLE at edge N -> o_rddata updated and o_rdvalid=1 after
//   edge N+P_RD_LATENCY-1 (i.e. visible cycle N+P_RD_LATENCY). Fully pipelined:
//   one read per cycle. o_rddata holds last value when o_rdvalid=0.
//  Reads in flight when CLEAR starts complete normally with pre-clear data.
//  Write: i_wren=1 in IDLE updates only lanes with i_wrbe[k]=1; i_wrbe=0 is no-op.
//  Same-address read+write same cycle: P_RDW_MODE=0 returns stored word before
//   the write; P_RDW_MODE=1 returns enabled lanes from i_wrdata, others stored.
//  Address >= P_LENGTH: write dropped; read returns 0 with o_rdvalid=1; either
//   sets o_err=1 (held until reset or i_clr accepted).
//  Different-address read+write same cycle: independent, no interaction.
// TESTING
//  T1 reset release: o_busy=1 for 1024 cycles then 0; read any addr -> 0.
//  T2 LAT=1: wr 0x0A=0xDEADBEEF be=4'hF, rd 0x0A -> 0xDEADBEEF, o_rdvalid 1 cycle
//   later; LAT=2 same data 2 cycles later; back-to-back reads 0..7 stream 1/cycle.
//  T3 byte enables: word=0x11223344, wr 0xAABBCCDD be=4'b0101 -> 0x11BB33DD.
//  T4 collision at addr 5 (old 0x0, wr 0xFFFFFFFF be=4'hF): MODE0 rd -> 0x0,
//   MODE1 rd -> 0xFFFFFFFF; be=4'b0011 in MODE1 -> 0x0000FFFF.
//  T5 P_LENGTH=1000: rd addr 1000 -> data 0, o_err=1; wr 1010 changes nothing;
//   i_clr -> o_err=0, o_busy 1000 cycles.
//  T6 assert i_rstn=0 at clear count 300; release -> o_busy full P_LENGTH
//   cycles, all words P_CLR_VALUE; i_clr mid-CLEAR does not extend busy.

Source files
------------

// File: rtl/sdpram_be_model.sv
// ---------------------------------------------------------------------------
// sdpram_be_model
//   Single-clock simple-dual-port RAM model with per-byte write enables,
//   a read latency of 1 or 2 cycles, a selectable same-address
//   read-during-write result and a hardware clear sequencer. It serves as
//   the quotient/remainder scratch store beside the divider datapath.
//
//   After reset, and after each accepted i_clr, the sequencer writes
//   P_CLR_VALUE to every word, one word per cycle. This takes exactly
//   P_LENGTH cycles. o_busy is high for that whole time, and reads and
//   writes are ignored.
//
// Ports
//   i_clk      clock; all logic uses the rising edge
//   i_rstn     asynchronous active-low reset
//   i_clr      start a clear sequence (ignored while o_busy)
//   o_busy     clear sequence running
//   i_rden     read request
//   i_rdaddr   read address
//   o_rddata   read data; holds its value when o_rdvalid is low
//   o_rdvalid  one-cycle pulse for each completed read
//   i_wren     write request
//   i_wrbe     byte enables; bit k covers bits [8k+7:8k]
//   i_wraddr   write address
//   i_wrdata   write data
//   o_err      sticky out-of-range access flag
// ---------------------------------------------------------------------------
module sdpram_be_model #(
    parameter int                    P_LENGTH     = 1024,
    parameter int                    P_ADDR_LEN   = 10,
    parameter int                    P_BITDEPTH   = 32,
    parameter int                    P_BE_WIDTH   = 4,
    parameter int                    P_RD_LATENCY = 1,
    parameter int                    P_RDW_MODE   = 0,
    parameter logic [P_BITDEPTH-1:0] P_CLR_VALUE  = '0
) (
    input  logic                  i_clk,
    input  logic                  i_rstn,
    input  logic                  i_clr,
    output logic                  o_busy,
    input  logic                  i_rden,
    input  logic [P_ADDR_LEN-1:0] i_rdaddr,
    output logic [P_BITDEPTH-1:0] o_rddata,
    output logic                  o_rdvalid,
    input  logic                  i_wren,
    input  logic [P_BE_WIDTH-1:0] i_wrbe,
    input  logic [P_ADDR_LEN-1:0] i_wraddr,
    input  logic [P_BITDEPTH-1:0] i_wrdata,
    output logic                  o_err
);

    typedef enum logic {
        ST_IDLE,
        ST_CLEAR
    } state_t;

    localparam logic [P_ADDR_LEN-1:0] LAST_ADDR = P_ADDR_LEN'(P_LENGTH - 1);

    state_t                  state;
    logic [P_ADDR_LEN-1:0]   clr_cnt;
    logic [P_BITDEPTH-1:0]   mem [P_LENGTH];

    logic                    rd_acc;
    logic                    wr_acc;
    logic                    rd_oob;
    logic                    wr_oob;
    logic [P_BITDEPTH-1:0]   be_mask;
    logic [P_BITDEPTH-1:0]   rd_word;

    // When i_clr is accepted, it takes priority and any access in the same
    // cycle is dropped.
    assign rd_acc = (state == ST_IDLE) && i_rden && !i_clr;
    assign wr_acc = (state == ST_IDLE) && i_wren && !i_clr;
    assign rd_oob = 32'(i_rdaddr) >= 32'(P_LENGTH);
    assign wr_oob = 32'(i_wraddr) >= 32'(P_LENGTH);

    // Expand the byte enables into a full-width bit mask. The write path and
    // the merged read-during-write result both use this mask.
    for (genvar g = 0; g < P_BE_WIDTH; g++) begin : g_mask
        assign be_mask[8*g +: 8] = {8{i_wrbe[g]}};
    end

    // Storage. It has no reset; the clear sequencer initialises the contents.
    always_ff @(posedge i_clk) begin
        if (state == ST_CLEAR) begin
            mem[clr_cnt] <= P_CLR_VALUE;
        end else if (wr_acc && !wr_oob) begin
            mem[i_wraddr] <= (mem[i_wraddr] & ~be_mask) | (i_wrdata & be_mask);
        end
    end

    // Word captured for a read. Out-of-range reads return zero. With
    // P_RDW_MODE=1, a same-address write in the same cycle is merged in.
    always_comb begin
        rd_word = '0;
        if (!rd_oob) begin
            rd_word = mem[i_rdaddr];
            if (P_RDW_MODE == 1 && wr_acc && i_wraddr == i_rdaddr) begin
                rd_word = (rd_word & ~be_mask) | (i_wrdata & be_mask);
            end
        end
    end

    // Read pipeline. The word is captured at the request edge. Because of
    // this, reads already in flight when a clear starts still return
    // pre-clear data.
    if (P_RD_LATENCY == 2) begin : g_lat2
        logic                  p_valid;
        logic [P_BITDEPTH-1:0] p_data;

        always_ff @(posedge i_clk or negedge i_rstn) begin
            if (!i_rstn) begin
                p_valid   <= 1'b0;
                p_data    <= '0;
                o_rdvalid <= 1'b0;
                o_rddata  <= '0;
            end else begin
                p_valid   <= rd_acc;
                if (rd_acc) begin
                    p_data <= rd_word;
                end
                o_rdvalid <= p_valid;
                if (p_valid) begin
                    o_rddata <= p_data;
                end
            end
        end
    end else begin : g_lat1
        always_ff @(posedge i_clk or negedge i_rstn) begin
            if (!i_rstn) begin
                o_rdvalid <= 1'b0;
                o_rddata  <= '0;
            end else begin
                o_rdvalid <= rd_acc;
                if (rd_acc) begin
                    o_rddata <= rd_word;
                end
            end
        end
    end

    // Control FSM, including the registered busy and error outputs.
    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            state   <= ST_CLEAR;
            clr_cnt <= '0;
            o_busy  <= 1'b1;
            o_err   <= 1'b0;
        end else if (state == ST_CLEAR) begin
            if (clr_cnt == LAST_ADDR) begin
                state  <= ST_IDLE;
                o_busy <= 1'b0;
            end else begin
                clr_cnt <= clr_cnt + P_ADDR_LEN'(1);
            end
        end else begin
            if (i_clr) begin
                state   <= ST_CLEAR;
                clr_cnt <= '0;
                o_busy  <= 1'b1;
                o_err   <= 1'b0;
            end else if ((rd_acc && rd_oob) || (wr_acc && wr_oob)) begin
                o_err <= 1'b1;
            end
        end
    end

endmodule
